image_row_ring: RTL

- Parametrised successor to the fixed 32-row image bank.
- Circular row buffer that holds DEPTH image rows of ROW_PIX pixels each.
- Accepts rows through a valid/ready write port. Returns a TAPS-row vertical window (rows r..r+TAPS-1) in one read, with optional pop.
- Sits between the image loader and the convolution/filter datapath of the image coprocessor. At end-of-image it replicates the last row so the kernel can reach the bottom edge.

---
 rtl/image_row_ring_if.sv | 36 +++
 rtl/image_row_ring.sv | 131 +++++++++++++
 2 files changed

// File: rtl/image_row_ring_if.sv
// Write/read/status bundle of the image row ring buffer.
// master = image loader plus filter datapath, slave = the ring itself.
interface image_row_ring_if #(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 384,
  parameter int DEPTH   = 32,
  parameter int TAPS    = 3
);
  localparam int ROW_W = PIX_W * ROW_PIX;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   flush;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ROW_W-1:0]       wr_data;
  logic                   wr_last;
  logic                   rd_req;
  logic                   rd_pop;
  logic                   rd_ready;
  logic                   rd_valid;
  logic [TAPS*ROW_W-1:0]  rd_rows;
  logic [CNT_W-1:0]       count;
  logic                   full;
  logic                   empty;
  logic                   eof;

  modport master (
    output flush, wr_valid, wr_data, wr_last, rd_req, rd_pop,
    input  wr_ready, rd_ready, rd_valid, rd_rows, count, full, empty, eof
  );

  modport slave (
    input  flush, wr_valid, wr_data, wr_last, rd_req, rd_pop,
    output wr_ready, rd_ready, rd_valid, rd_rows, count, full, empty, eof
  );
endinterface

// File: rtl/image_row_ring.sv
// Circular buffer of DEPTH image rows returning a TAPS-row vertical window per read.
// At end-of-image the bottom row is replicated into taps past the stored rows.
module image_row_ring #(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 384,
  parameter int DEPTH   = 32,
  parameter int TAPS    = 3
) (
  input logic             clk,
  input logic             rst_n,
  image_row_ring_if.slave bus
);
  localparam int ROW_W = PIX_W * ROW_PIX;
  localparam int WIN_W = TAPS * ROW_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_TAPS = CNT_W'(TAPS);
  localparam logic [SUM_W-1:0] SUM_DEPTH = SUM_W'(DEPTH);

  // Offsets never exceed DEPTH-1, so a single conditional subtract wraps any depth.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [CNT_W-1:0] off);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(off);
    if (sum >= SUM_DEPTH) sum = sum - SUM_DEPTH;
    return sum[PTR_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [ROW_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             eof_q, eof_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIN_W-1:0] rd_rows_q, rd_rows_d;

  logic             full, rd_ready;
  logic             wr_accept, rd_accept, pop_accept;
  logic [CNT_W-1:0] bottom_off;
  logic [WIN_W-1:0] window;

  assign full     = (count_q == CNT_FULL);
  assign rd_ready = (count_q >= CNT_TAPS) | (eof_q & (count_q != '0));

  assign bus.full     = full;
  assign bus.empty    = (count_q == '0);
  assign bus.count    = count_q;
  assign bus.eof      = eof_q;
  assign bus.wr_ready = ~full;
  assign bus.rd_ready = rd_ready;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_rows  = rd_rows_q;

  // Taps past the stored rows repeat the bottom row (only reachable with eof set).
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    window     = '0;
    bottom_off = (count_q == '0) ? '0 : count_q - CNT_W'(1);
    for (int k = 0; k < TAPS; k++) begin
      if (CNT_W'(k) < count_q)
        window[k*ROW_W +: ROW_W] = mem[wrap_add(rd_ptr_q, CNT_W'(k))];
      else
        window[k*ROW_W +: ROW_W] = mem[wrap_add(rd_ptr_q, bottom_off)];
    end
  end

  always_comb begin
    wr_accept  = bus.wr_valid & ~full & ~bus.flush;
    rd_accept  = bus.rd_req & rd_ready & ~bus.flush;
    pop_accept = rd_accept & bus.rd_pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    eof_d      = eof_q;
    rd_valid_d = 1'b0;
    rd_rows_d  = rd_rows_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      eof_d    = 1'b0;
    end else begin
      if (wr_accept)  wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_accept) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_accept, pop_accept})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wr_accept & bus.wr_last)          eof_d = 1'b1;
      if (pop_accept && (count_d == '0))    eof_d = 1'b0;
      rd_valid_d = rd_accept;
      if (rd_accept) rd_rows_d = window;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      eof_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_rows_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      eof_q      <= eof_d;
      rd_valid_q <= rd_valid_d;
      rd_rows_q  <= rd_rows_d;
    end
  end

  // NOTE: row storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= bus.wr_data;
  end
endmodule
